// File: rtl/game_sequencer_if.sv
// game_sequencer_if: frame timer / datapath handshake bundle around the frame sequencer.
interface game_sequencer_if #(
  parameter int NUM_SPRITES = 4,
  parameter int IDX_W = 4
);
  logic frame_tick;
  logic pause;
  logic [NUM_SPRITES-1:0] sprite_en;
  logic collide_done;
  logic map_done;
  logic sprite_done;
  logic [3:0] state;
  logic init;
  logic idle;
  logic gen_move;
  logic check_collide;
  logic apply_act_link;
  logic move_enemies;
  logic draw_map;
  logic draw_sprite;
  logic [IDX_W-1:0] sprite_idx;
  logic [15:0] frame_count;
  logic tick_pending;
  logic overrun;
  logic timeout_err;
  modport master (
    output frame_tick, pause, sprite_en, collide_done, map_done, sprite_done,
    input state, init, idle, gen_move, check_collide, apply_act_link, move_enemies,
    input draw_map, draw_sprite, sprite_idx, frame_count, tick_pending, overrun, timeout_err
  );
  modport slave (
    input frame_tick, pause, sprite_en, collide_done, map_done, sprite_done,
    output state, init, idle, gen_move, check_collide, apply_act_link, move_enemies,
    output draw_map, draw_sprite, sprite_idx, frame_count, tick_pending, overrun, timeout_err
  );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: Moore FSM ordering per-frame phases with sprite iteration, tick latch and watchdog.
module game_sequencer #(
  parameter int NUM_SPRITES = 4,
  parameter int IDX_W = 4,
  parameter int TIMEOUT = 65535,
  parameter int TO_W = 16
) (
  input logic clock,
  input logic reset,
  game_sequencer_if.slave bus
);
  typedef enum logic [3:0] {
    INIT = 4'd0, IDLE = 4'd1, GEN = 4'd2, COLL = 4'd3,
    LINK = 4'd4, MOVE = 4'd5, MAP = 4'd6, SPRITE = 4'd7
  } state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, lo_idx, hi_idx;
  logic [NUM_SPRITES-1:0] mask_q, mask_d;
  logic [15:0] fc_q, fc_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic pend_q, pend_d, ovr_q, ovr_d, terr_q, terr_d;
  logic hi_ok, waiting, done, expire, adv, tick;
  assign tick = bus.frame_tick;
  assign waiting = state_q inside {COLL, MAP, SPRITE};
  assign done = (state_q == COLL && bus.collide_done) || (state_q == MAP && bus.map_done) ||
                (state_q == SPRITE && bus.sprite_done);
  assign expire = waiting && !done && wd_q == TO_W'(TIMEOUT - 1);
  assign adv = done || expire;
  // Descending scan leaves the lowest qualifying bit in each result.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    hi_ok = 1'b0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (bus.sprite_en[i]) lo_idx = IDX_W'(i);
      if (mask_q[i] && IDX_W'(i) > idx_q) begin
        hi_idx = IDX_W'(i);
        hi_ok = 1'b1;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    mask_d = mask_q;
    fc_d = fc_q;
    pend_d = state_q == IDLE ? 1'b0 : pend_q | tick;
    ovr_d = ovr_q | (state_q != IDLE && tick && pend_q);
    terr_d = terr_q | expire;
    case (state_q)
      INIT: state_d = MAP;
      IDLE: if (tick || pend_q) state_d = bus.pause ? MAP : GEN;
      GEN: state_d = COLL;
      COLL: if (adv) state_d = LINK;
      LINK: state_d = MOVE;
      MOVE: state_d = MAP;
      MAP: if (adv) begin
        mask_d = bus.sprite_en;
        if (|bus.sprite_en) begin
          state_d = SPRITE;
          idx_d = lo_idx;
        end else begin
          state_d = IDLE;
          fc_d = fc_q + 16'd1;
        end
      end
      SPRITE: if (adv) begin
        if (hi_ok) idx_d = hi_idx;
        else begin
          state_d = IDLE;
          fc_d = fc_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    wd_d = (waiting && state_d == state_q && idx_d == idx_q) ? wd_q + TO_W'(1) : '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INIT;
      idx_q <= '0;
      mask_q <= '0;
      fc_q <= '0;
      wd_q <= '0;
      pend_q <= 1'b0;
      ovr_q <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      mask_q <= mask_d;
      fc_q <= fc_d;
      wd_q <= wd_d;
      pend_q <= pend_d;
      ovr_q <= ovr_d;
      terr_q <= terr_d;
    end
  end
  assign bus.state = state_q;
  assign bus.init = state_q == INIT;
  assign bus.idle = state_q == IDLE;
  assign bus.gen_move = state_q == GEN;
  assign bus.check_collide = state_q == COLL;
  assign bus.apply_act_link = state_q == LINK;
  assign bus.move_enemies = state_q == MOVE;
  assign bus.draw_map = state_q == MAP;
  assign bus.draw_sprite = state_q == SPRITE;
  assign bus.sprite_idx = idx_q;
  assign bus.frame_count = fc_q;
  assign bus.tick_pending = pend_q;
  assign bus.overrun = ovr_q;
  assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed test-plan frames plus random traffic checked against a phase-level model.
module tb_game_sequencer;
  localparam int NS = 4;
  localparam int TO = 8;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errs = 0;
  game_sequencer_if #(.NUM_SPRITES(NS), .IDX_W(4)) gi();
  game_sequencer #(.NUM_SPRITES(NS), .IDX_W(4), .TIMEOUT(TO), .TO_W(16)) dut (
    .clock(clock), .reset(reset), .bus(gi)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: phase number, a queue of sprites still to draw, and dwell time in the current wait.
  int m_phase, m_dwell;
  int m_q[$];
  logic [15:0] m_fc;
  bit m_pend, m_ovr, m_terr, armed, tk, old_pend, dn, fire;
  always @(posedge clock) begin
    if (reset) begin
      m_phase = 0; m_dwell = 0; m_q.delete(); m_fc = 0;
      m_pend = 0; m_ovr = 0; m_terr = 0; armed = 1;
    end else if (armed) begin
      tk = gi.frame_tick;
      old_pend = m_pend;
      if (m_phase != 1) begin
        if (tk && m_pend) m_ovr = 1;
        m_pend = m_pend | tk;
      end else m_pend = 0;
      dn = (m_phase == 3 && gi.collide_done) || (m_phase == 6 && gi.map_done) ||
           (m_phase == 7 && gi.sprite_done);
      fire = 0;
      if (m_phase == 3 || m_phase == 6 || m_phase == 7) begin
        if (dn || m_dwell == TO - 1) begin
          fire = 1;
          if (!dn) m_terr = 1;
          m_dwell = 0;
        end else m_dwell++;
      end
      case (m_phase)
        0: m_phase = 6;
        1: if (tk || old_pend) m_phase = gi.pause ? 6 : 2;
        2: m_phase = 3;
        3: if (fire) m_phase = 4;
        4: m_phase = 5;
        5: m_phase = 6;
        6: if (fire) begin
          m_q.delete();
          for (int i = 0; i < NS; i++) if (gi.sprite_en[i]) m_q.push_back(i);
          if (m_q.size() == 0) begin m_phase = 1; m_fc++; end else m_phase = 7;
        end
        7: if (fire) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin m_phase = 1; m_fc++; end
        end
        default: m_phase = 1;
      endcase
    end
  end
  always @(negedge clock) begin
    if (armed) begin
      chk("state", int'(gi.state), m_phase);
      chk("strobes", int'({gi.draw_sprite, gi.draw_map, gi.move_enemies, gi.apply_act_link,
          gi.check_collide, gi.gen_move, gi.idle, gi.init}), 1 << m_phase);
      if (m_phase == 7) chk("sprite_idx", int'(gi.sprite_idx), m_q[0]);
      chk("frame_count", int'(gi.frame_count), int'(m_fc));
      chk("tick_pending", int'(gi.tick_pending), int'(m_pend));
      chk("overrun", int'(gi.overrun), int'(m_ovr));
      chk("timeout_err", int'(gi.timeout_err), int'(m_terr));
    end
  end
  task automatic step();
    @(negedge clock);
  endtask
  task automatic run_to_map();
    step(); chk("t_gen", int'(gi.gen_move), 1);
    gi.frame_tick = 0;
    step(); gi.collide_done = 1;
    step(); chk("t_link", int'(gi.state), 4); gi.collide_done = 0;
    step(); step(); chk("t_map", int'(gi.state), 6);
  endtask
  initial begin
    gi.frame_tick = 0; gi.pause = 0; gi.sprite_en = 4'b0101;
    gi.collide_done = 0; gi.map_done = 0; gi.sprite_done = 0;
    repeat (2) step();
    reset = 0;
    chk("t1_init", int'(gi.init), 1);
    chk("t1_fc0", int'(gi.frame_count), 0);
    step(); chk("t1_map", int'(gi.state), 6); gi.map_done = 1;
    step(); chk("t1_spr", int'(gi.state), 7); chk("t1_idx0", int'(gi.sprite_idx), 0);
    gi.map_done = 0; gi.sprite_done = 1;
    step(); chk("t1_idx2", int'(gi.sprite_idx), 2);
    step(); chk("t1_idle", int'(gi.state), 1); chk("t1_fc1", int'(gi.frame_count), 1);
    gi.sprite_done = 0; gi.sprite_en = 0; gi.frame_tick = 1;
    step(); chk("t2_gen", int'(gi.gen_move), 1); gi.frame_tick = 0;
    repeat (5) step();
    chk("t2_coll", int'(gi.check_collide), 1); gi.collide_done = 1;
    step(); chk("t2_link", int'(gi.apply_act_link), 1); gi.collide_done = 0;
    step(); chk("t2_move", int'(gi.move_enemies), 1);
    step(); chk("t2_map", int'(gi.draw_map), 1); gi.map_done = 1;
    step(); chk("t2_idle", int'(gi.idle), 1); chk("t2_fc2", int'(gi.frame_count), 2);
    gi.map_done = 0; gi.pause = 1; gi.frame_tick = 1;
    step(); chk("t3_map", int'(gi.state), 6);
    gi.frame_tick = 0; gi.pause = 0; gi.map_done = 1;
    step(); chk("t3_idle", int'(gi.state), 1); chk("t3_fc3", int'(gi.frame_count), 3);
    gi.map_done = 0; gi.frame_tick = 1;
    step(); gi.frame_tick = 0;
    step(); chk("t4_coll", int'(gi.state), 3); gi.frame_tick = 1;
    step(); chk("t4_pend", int'(gi.tick_pending), 1); chk("t4_ovr0", int'(gi.overrun), 0);
    step(); chk("t4_ovr1", int'(gi.overrun), 1);
    gi.frame_tick = 0; gi.collide_done = 1;
    step(); gi.collide_done = 0;
    step(); step(); chk("t4_map", int'(gi.state), 6); gi.map_done = 1;
    step(); chk("t4_idle", int'(gi.state), 1); chk("t4_pend_idle", int'(gi.tick_pending), 1);
    gi.map_done = 0;
    step(); chk("t4_gen", int'(gi.state), 2); chk("t4_pend_clr", int'(gi.tick_pending), 0);
    step(); gi.collide_done = 1;
    step(); gi.collide_done = 0;
    step(); step(); chk("t5_map", int'(gi.state), 6);
    repeat (7) step();
    chk("t5_still_map", int'(gi.state), 6); chk("t5_terr0", int'(gi.timeout_err), 0);
    step(); chk("t5_idle", int'(gi.state), 1); chk("t5_terr1", int'(gi.timeout_err), 1);
    gi.frame_tick = 1;
    run_to_map(); gi.map_done = 1;
    step(); chk("t5_terr_sticky", int'(gi.timeout_err), 1);
    gi.map_done = 0; gi.sprite_en = 4'b0101; gi.frame_tick = 1;
    run_to_map(); gi.map_done = 1;
    step(); chk("t6_idx0", int'(gi.sprite_idx), 0); gi.map_done = 0; gi.sprite_done = 1;
    step(); chk("t6_idx2", int'(gi.sprite_idx), 2); gi.sprite_done = 0; reset = 1;
    step();
    chk("t6_init", int'(gi.state), 0); chk("t6_idx", int'(gi.sprite_idx), 0);
    chk("t6_fc", int'(gi.frame_count), 0); chk("t6_ovr", int'(gi.overrun), 0);
    chk("t6_terr", int'(gi.timeout_err), 0); chk("t6_pend", int'(gi.tick_pending), 0);
    reset = 0;
    for (int n = 0; n < 4000; n++) begin
      step();
      gi.frame_tick = $urandom_range(0, 9) == 0;
      gi.pause = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 15) == 0) gi.sprite_en = 4'($urandom);
      gi.collide_done = $urandom_range(0, 4) == 0;
      gi.map_done = $urandom_range(0, 5) == 0;
      gi.sprite_done = $urandom_range(0, 3) == 0;
      reset = $urandom_range(0, 599) == 0;
    end
    reset = 0;
    step(); step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Parametrised top-level frame sequencer for the game engine. Moore FSM that orders per-frame phases: idle, generate movement, collision check, Link action, enemy move, map draw, then N sprite draws.
- Generalises the single-enemy control FSM:
  - iterates over NUM_SPRITES draw channels, with a per-sprite enable mask;
  - supports pause (redraw-only frames);
  - latches frame ticks that arrive while busy;
  - runs a watchdog on every wait phase.
- Sits between the frame timer and the datapath.

Parameters:
- NUM_SPRITES, 4, number of sprite draw channels (1..16).
- IDX_W, 4, width of sprite_idx; must satisfy 2^IDX_W >= NUM_SPRITES.
- TIMEOUT, 65535, max cycles spent in any wait state before forced advance (>= 2).
- TO_W, 16, watchdog counter width; must hold TIMEOUT.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle frame-start pulse from timer
- pause  in  1  level; when high, frames skip update phases
- sprite_en  in  NUM_SPRITES  bit i enables drawing of sprite i
- collide_done  in  1  collision check finished
- map_done  in  1  map draw finished
- sprite_done  in  1  current sprite draw finished
- state  out  4  current state encoding
- init, idle, gen_move, check_collide, apply_act_link, move_enemies, draw_map, draw_sprite  out  1 each  one-hot phase strobes, decoded from the registered state
- sprite_idx  out  IDX_W  sprite being drawn; valid while draw_sprite=1
- frame_count  out  16  completed frames, wraps 0xFFFF->0
- tick_pending  out  1  a frame tick is latched and not yet consumed
- overrun  out  1  sticky: frame_tick arrived while tick_pending already 1
- timeout_err  out  1  sticky: watchdog forced an advance

Behaviour:
- State encoding: INIT=0, IDLE=1, GEN=2, COLL=3, LINK=4, MOVE=5, MAP=6, SPRITE=7. Unused codes go to IDLE next cycle.
- Reset:
  - state=INIT, sprite_idx=0, frame_count=0, tick_pending=0, overrun=0, timeout_err=0, watchdog=0, sprite mask snapshot=0.
  - Strobes follow state, so init=1 and all other strobes are 0.
  - Reset mid-frame aborts immediately; no done input is honoured in the reset cycle.
- Strobes are purely combinational from state, so exactly one strobe is high in every cycle.
- Transitions (one clock each):
  - INIT -> MAP, unconditionally.
  - IDLE: if (frame_tick | tick_pending), go to GEN, or to MAP when pause=1. Otherwise stay.
  - GEN -> COLL.
  - COLL: on collide_done or timeout, go to LINK.
  - LINK -> MOVE.
  - MOVE -> MAP.
  - MAP: on map_done or timeout, capture sprite_en into the mask snapshot. If the snapshot is nonzero, go to SPRITE with sprite_idx = lowest set bit; otherwise go to IDLE and increment frame_count.
  - SPRITE: on sprite_done or timeout, if a higher set bit exists in the snapshot, load sprite_idx with it and stay in SPRITE. Otherwise go to IDLE and increment frame_count.
- sprite_en changes after the MAP exit have no effect until the next frame.
- Tick latch:
  - tick_pending is set when frame_tick=1 and state!=IDLE.
  - tick_pending is cleared on the IDLE exit cycle.
  - If frame_tick=1 while tick_pending=1 and state!=IDLE, set overrun. Ticks beyond one are dropped.
  - A tick in IDLE is consumed directly and never sets pending.
  - A tick that coincides with the SPRITE->IDLE or MAP->IDLE cycle sets pending. IDLE then exits on the next cycle.
- Watchdog:
  - Counts only in COLL, MAP and SPRITE.
  - Clears on any state change and on any sprite_idx change.
  - When the count equals TIMEOUT-1 and done is low, the FSM advances as if done were high and sets timeout_err. The maximum dwell is therefore TIMEOUT cycles.
  - If done arrives in the same cycle as the timeout, it is a normal advance and timeout_err is not set.
- Pause is sampled only at the IDLE exit. Changing pause mid-frame does not alter the current frame.
- Done inputs asserted outside their own state are ignored.

Test Plan:
1. Reset, then run with map_done pulsed at cycle 3 and sprite_en=4'b0101 -> sequence INIT, MAP, SPRITE idx0, SPRITE idx2, IDLE; frame_count=1.
2. In IDLE with pause=0, give frame_tick, then collide_done after 5 cycles -> GEN(1), COLL(6), LINK, MOVE, MAP strobes in order; with sprite_en=0, MAP goes straight to IDLE and frame_count increments.
3. pause=1 with frame_tick in IDLE -> next state MAP; gen_move, check_collide, apply_act_link and move_enemies are never asserted that frame.
4. Issue two frame_ticks during COLL -> tick_pending=1, overrun=1. After the frame ends, IDLE lasts exactly 1 cycle and GEN follows.
5. TIMEOUT=8, never assert map_done -> exactly 8 cycles in MAP, then advance, timeout_err=1 until reset; a later normal frame leaves it at 1.
6. Assert reset for 1 cycle mid-SPRITE (idx=2) -> next state INIT, sprite_idx=0, frame_count=0, all sticky flags 0.
